// File: rtl/mac_pkg.sv
// Shared definitions for the Booth multiply-accumulate unit: default widths,
// sequencing states and the radix-2 Booth step encoding.
package mac_pkg;

   localparam int unsigned MAC_DATA_W = 16;
   localparam int unsigned MAC_ACC_W  = 40;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      ACC  = 2'd2
   } mac_state_t;

   // Booth step selected by {Q[0], Q-1}
   localparam logic [1:0] BOOTH_NOP_LO = 2'b00;
   localparam logic [1:0] BOOTH_ADD    = 2'b01;
   localparam logic [1:0] BOOTH_SUB    = 2'b10;
   localparam logic [1:0] BOOTH_NOP_HI = 2'b11;

endpackage

// File: rtl/mac_unit_booth_mult.sv
// Sequential radix-2 Booth multiplier: one add/sub-and-shift step per cycle,
// DATA_W steps per product, signed 2*DATA_W result held until the next start.
module booth_mult
   import mac_pkg::*;
#(
   parameter int unsigned DATA_W = MAC_DATA_W
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic        [DATA_W-1:0]     m_in,
   input  logic        [DATA_W-1:0]     q_in,
   output logic                         done,
   output logic signed [2*DATA_W-1:0]   result
);

   localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

   logic              busy_q, busy_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   // A and M carry one guard bit so that subtracting M = -2^(DATA_W-1) cannot overflow
   logic [DATA_W:0]   m_q, m_d;
   logic [DATA_W:0]   a_q, a_d;
   logic [DATA_W-1:0] q_q, q_d;
   logic              qm1_q, qm1_d;
   logic [DATA_W:0]   a_sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         m_q    <= '0;
         a_q    <= '0;
         q_q    <= '0;
         qm1_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         m_q    <= m_d;
         a_q    <= a_d;
         q_q    <= q_d;
         qm1_q  <= qm1_d;
      end
   end

   always_comb begin
      a_sum = a_q;
      case ({q_q[0], qm1_q})
         BOOTH_ADD:    a_sum = a_q + m_q;
         BOOTH_SUB:    a_sum = a_q - m_q;
         BOOTH_NOP_LO: a_sum = a_q;
         BOOTH_NOP_HI: a_sum = a_q;
         default:      a_sum = a_q;
      endcase
   end

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      m_d    = m_q;
      a_d    = a_q;
      q_d    = q_q;
      qm1_d  = qm1_q;
      if (!busy_q) begin
         if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            m_d    = {m_in[DATA_W-1], m_in};
            a_d    = '0;
            q_d    = q_in;
            qm1_d  = 1'b0;
         end
      end else begin
         // Arithmetic right shift of {A, Q, Q-1} after the add/sub
         a_d   = {a_sum[DATA_W], a_sum[DATA_W:1]};
         q_d   = {a_sum[0], q_q[DATA_W-1:1]};
         qm1_d = q_q[0];
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == LAST_STEP) begin
            busy_d = 1'b0;
            cnt_d  = '0;
         end
      end
   end

   assign done   = busy_q && (cnt_q == LAST_STEP);
   assign result = {a_q[DATA_W-1:0], q_q};

endmodule

// File: rtl/mac_unit.sv
// Signed multiply-accumulate leaf: sequences the Booth multiplier, adds each
// sign-extended product into a wrapping accumulator and pulses ready when done.
module mac_unit
   import mac_pkg::*;
#(
   parameter int unsigned DATA_W = MAC_DATA_W,
   parameter int unsigned ACC_W  = MAC_ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] m_in,
   input  logic [DATA_W-1:0] q_in,
   input  logic              clr_acc,
   output logic [ACC_W-1:0]  product,
   output logic              ready
);

   mac_state_t state_q, state_d;
   logic [ACC_W-1:0] product_q, product_d;
   logic             ready_q, ready_d;
   logic             mult_start;
   logic             mult_done;
   logic signed [2*DATA_W-1:0] mult_res;
   logic [ACC_W-1:0] prod_ext;

   booth_mult #(
      .DATA_W (DATA_W)
   ) u_booth_mult (
      .clk    (clk),
      .rst    (rst),
      .start  (mult_start),
      .m_in   (m_in),
      .q_in   (q_in),
      .done   (mult_done),
      .result (mult_res)
   );

   assign prod_ext = ACC_W'(mult_res);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         product_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         product_q <= product_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CALC;
         CALC:    if (mult_done) state_d = ACC;
         ACC:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mult_start = (state_q == IDLE) && start;
      ready_d    = (state_q == ACC);
      product_d  = product_q;
      if (state_q == ACC) begin
         // A clear in the ACC cycle discards the old total but keeps the new product
         product_d = (clr_acc ? '0 : product_q) + prod_ext;
      end else if (clr_acc) begin
         product_d = '0;
      end
   end

   assign product = product_q;
   assign ready   = ready_q;

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: directed operations push expected totals and
// ready timing; a monitor pops and compares on every ready pulse.
module tb_mac_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] m_in = '0;
   logic [15:0] q_in = '0;
   logic        clr_acc = 1'b0;
   logic [39:0] product;
   logic        ready;

   typedef struct {
      logic [39:0] exp;
      int          cyc;
   } sb_t;

   sb_t sb[$];
   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   int  ready_seen = 0;

   mac_unit #(
      .DATA_W (16),
      .ACC_W  (40)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .m_in    (m_in),
      .q_in    (q_in),
      .clr_acc (clr_acc),
      .product (product),
      .ready   (ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: every ready pulse consumes one scoreboard entry
   always @(negedge clk) begin
      if (ready === 1'b1) begin
         ready_seen++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got ready at cycle %0d expected none", cyc);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("product", product, e.exp);
            check("ready_latency", 40'(cyc), 40'(e.cyc));
         end
      end
   end

   // Issue one operation; k counts cycles after issue for mid-flight events.
   task automatic run_op(input int m, input int q, input longint exp, input bit push,
                         input int clr_k, input int restart_k, input int rst_k);
      int issue;
      @(posedge clk); #1;
      m_in  = 16'(m);
      q_in  = 16'(q);
      start = 1'b1;
      issue = cyc;
      if (push) sb.push_back('{exp: 40'(exp), cyc: issue + 18});
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         start   = 1'b0;
         m_in    = 16'($urandom);
         q_in    = 16'($urandom);
         clr_acc = (k == clr_k);
         rst     = (k == rst_k);
         if (k == restart_k) begin
            start = 1'b1;
            m_in  = 16'd100;
            q_in  = 16'd100;
         end
         if (k >= 19 && (!push || sb.size() == 0)) break;
      end
      start   = 1'b0;
      clr_acc = 1'b0;
      rst     = 1'b0;
      if (push && sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL ready_timeout: got no ready expected product %h", 40'(exp));
         sb.delete();
      end
   endtask

   task automatic clear_idle();
      @(posedge clk); #1;
      clr_acc = 1'b1;
      @(posedge clk); #1;
      clr_acc = 1'b0;
      check("clear_idle", product, 40'h0);
   endtask

   initial begin
      int seen_before;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_product", product, 40'h0);
      check("reset_ready", {39'h0, ready}, 40'h0);

      run_op(10, 10, 100, 1'b1, -1, -1, -1);
      run_op(5, 2, 110, 1'b1, -1, -1, -1);
      run_op(2, -3, 104, 1'b1, -1, -1, -1);
      clear_idle();
      run_op(-7, 6, -42, 1'b1, -1, -1, -1);
      clear_idle();
      run_op(-32768, -32768, 1073741824, 1'b1, -1, -1, -1);
      run_op(32767, -32768, 32768, 1'b1, -1, -1, -1);
      // start mid-CALC must be ignored: 32768 + 9*(-4)
      run_op(9, -4, 32732, 1'b1, -1, 5, -1);
      // clear during CALC wipes the total but not the running product
      run_op(3, 5, 15, 1'b1, 5, -1, -1);
      // clear in the ACC cycle leaves only the new product
      run_op(7, 8, 56, 1'b1, 17, -1, -1);

      seen_before = ready_seen;
      run_op(11, 11, 0, 1'b0, -1, -1, 5);
      check("reset_mid_product", product, 40'h0);
      check("reset_mid_no_ready", 40'(ready_seen), 40'(seen_before));
      run_op(3, 4, 12, 1'b1, -1, -1, -1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

endmodule
